axi_llc_miss_counter: RTL and testbench

Tracks the number of descriptors per AXI ID and direction currently inside the eviction/refill pipeline, and decides for every new descriptor from the hit/miss detection whether it may take the hit bypass or must enter the miss pipeline to preserve per-ID AXI ordering. It sits upstream of the merge unit. It counts up when the hit/miss stage routes a descriptor into the pipeline, and counts down on the merge unit's `cnt_down` strobe when a descriptor leaves the pipeline.

---
 rtl/axi_llc_pkg.sv | 16 +
 rtl/axi_llc_miss_counter_if.sv | 26 ++
 rtl/axi_llc_miss_cnt_slice.sv | 56 +++++
 rtl/axi_llc_miss_counter.sv | 110 +++++++++++
 tb/tb_axi_llc_miss_counter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_llc_pkg.sv
// Shared types and defaults for the LLC miss counter and the hit/miss unit.
//   DefaultIdWidth  : default AXI slave ID width
//   DefaultCntWidth : default outstanding-descriptor counter width
//   cnt_t           : decrement strobe payload (same type as the merge unit's cnt_down_o)
package axi_llc_pkg;

  localparam int unsigned DefaultIdWidth  = 32'd4;
  localparam int unsigned DefaultCntWidth = 32'd4;

  typedef struct packed {
    logic [DefaultIdWidth-1:0] id;
    logic                      rw;
    logic                      valid;
  } cnt_t;

endpackage

// File: rtl/axi_llc_miss_counter_if.sv
// Lookup request channel between the hit/miss unit and the miss counter.
//   req_valid/req_id/req_rw/req_hit : request from the hit/miss unit
//   req_ready                       : request accepted (combinational)
//   route_miss                      : 1 = miss pipeline, 0 = hit bypass (combinational)
interface axi_llc_miss_counter_if #(
  parameter int unsigned IdWidth = axi_llc_pkg::DefaultIdWidth
);

  logic               req_valid;
  logic               req_ready;
  logic [IdWidth-1:0] req_id;
  logic               req_rw;
  logic               req_hit;
  logic               route_miss;

  modport master (
    output req_valid, req_id, req_rw, req_hit,
    input  req_ready, route_miss
  );

  modport slave (
    input  req_valid, req_id, req_rw, req_hit,
    output req_ready, route_miss
  );

endinterface

// File: rtl/axi_llc_miss_cnt_slice.sv
// One saturating up/down counter of descriptors in flight for a single {rw, id} index.
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i, dec_i : count up / count down strobes (both together leave the value unchanged)
//   cnt_o        : current count
//   full_o       : count at maximum
//   zero_o       : count is zero
//   zero_nxt_o   : count will be zero after this cycle
//   underflow_o  : decrement requested at zero (counter holds at zero)
module axi_llc_miss_cnt_slice #(
  parameter int unsigned CntWidth = axi_llc_pkg::DefaultCntWidth,
  parameter bit          EnAssert = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                full_o,
  output logic                zero_o,
  output logic                zero_nxt_o,
  output logic                underflow_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CntWidth-1:0] cnt_d, cnt_q;

  // Next-count computation; saturates at both ends.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
      2'b01: begin
        if (cnt_q == '0) underflow_o = 1'b1;
        else             cnt_d       = cnt_q - CntWidth'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign full_o     = (cnt_q == CntMax);
  assign zero_o     = (cnt_q == '0);
  assign zero_nxt_o = (cnt_d == '0);

  // A decrement with nothing in flight means upstream and merge unit disagree.
  assert property (@(posedge clk_i) disable iff (rst_i || !EnAssert) !underflow_o)
    else $error("axi_llc_miss_cnt_slice: decrement at zero count");

endmodule

// File: rtl/axi_llc_miss_counter.sv
// Per-{rw, ID} count of descriptors inside the eviction/refill pipeline; decides whether a new
// descriptor may take the hit bypass or must follow earlier same-ID descriptors through the
// miss pipeline.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req          : lookup request channel (slave side), ready/route are combinational
//   cnt_down_i   : decrement strobe from the merge unit, always accepted
//   empty_o      : all counters zero (registered)
//   err_o        : sticky underflow error, cleared by reset only
module axi_llc_miss_counter
  import axi_llc_pkg::*;
#(
  parameter int unsigned IdWidth  = 32'd4,
  parameter int unsigned IdxWidth = 32'd3,
  parameter int unsigned CntWidth = DefaultCntWidth,
  parameter type         cnt_t    = axi_llc_pkg::cnt_t,
  parameter bit          EnAssert = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  axi_llc_miss_counter_if.slave         req,
  input  cnt_t                          cnt_down_i,
  output logic                          empty_o,
  output logic                          err_o
);

  localparam int unsigned KeyWidth = IdxWidth + 32'd1;
  localparam int unsigned NumCnt   = 32'd2 ** KeyWidth;

  logic [KeyWidth-1:0] req_idx, dn_idx;
  logic [CntWidth-1:0] cnt [NumCnt];
  logic [NumCnt-1:0]   inc, dec, full, zero, zero_nxt, underflow;

  logic                dn_same;
  logic [CntWidth-1:0] eff;
  logic                eff_full;
  logic                route_miss_c, req_ready_c;

  logic                empty_d, empty_q, err_d, err_q;

  // Low ID bits select the counter; aliased IDs share one, which only costs bypass chances.
  assign req_idx = {req.req_rw, req.req_id[IdxWidth-1:0]};
  assign dn_idx  = {cnt_down_i.rw, cnt_down_i.id[IdxWidth-1:0]};

  logic unused_id_bits;
  assign unused_id_bits = ^{req.req_id, cnt_down_i.id};

  for (genvar k = 0; k < NumCnt; k++) begin : gen_cnt
    axi_llc_miss_cnt_slice #(
      .CntWidth (CntWidth),
      .EnAssert (EnAssert)
    ) u_slice (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (inc[k]),
      .dec_i       (dec[k]),
      .cnt_o       (cnt[k]),
      .full_o      (full[k]),
      .zero_o      (zero[k]),
      .zero_nxt_o  (zero_nxt[k]),
      .underflow_o (underflow[k])
    );
  end

  // Routing decision. A same-index descriptor leaving this cycle is already in the merge stage,
  // so it no longer blocks the bypass; eff saturates at zero on a bogus decrement.
  always_comb begin
    dn_same      = 1'b0;
    eff          = '0;
    eff_full     = 1'b0;
    route_miss_c = 1'b0;
    req_ready_c  = 1'b0;
    inc          = '0;
    dec          = '0;

    dn_same = cnt_down_i.valid && (dn_idx == req_idx);
    eff     = cnt[req_idx];
    if (dn_same && !zero[req_idx]) eff = cnt[req_idx] - CntWidth'(1);
    eff_full = full[req_idx] && !dn_same;

    route_miss_c = !req.req_hit || (eff != '0);
    // A full counter stalls only requests that would need to increment it.
    req_ready_c  = !(route_miss_c && eff_full);

    if (req.req_valid && req_ready_c && route_miss_c) inc[req_idx] = 1'b1;
    if (cnt_down_i.valid)                              dec[dn_idx]  = 1'b1;
  end

  assign req.route_miss = route_miss_c;
  assign req.req_ready  = req_ready_c;

  // Status flags: empty looks at next counter values, error is sticky.
  always_comb begin
    empty_d = &zero_nxt;
    err_d   = err_q | (|underflow);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign empty_o = empty_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_axi_llc_miss_counter.sv
// Directed bench for axi_llc_miss_counter: bypass/miss routing, full stall with same-cycle
// release, same-cycle decrement bypass, sticky underflow error and low-bit ID aliasing.
module tb_axi_llc_miss_counter;
  import axi_llc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req_valid;
  logic [3:0] req_id;
  logic       req_rw;
  logic       req_hit;
  cnt_t       cnt_down, cnt_down_idle;

  logic empty, err, empty_a, err_a;

  int n_cmp = 0;
  int n_err = 0;

  axi_llc_miss_counter_if #(.IdWidth(4)) req_if ();
  axi_llc_miss_counter_if #(.IdWidth(4)) req_if_a ();

  assign req_if.req_valid   = req_valid;
  assign req_if.req_id      = req_id;
  assign req_if.req_rw      = req_rw;
  assign req_if.req_hit     = req_hit;
  assign req_if_a.req_valid = req_valid;
  assign req_if_a.req_id    = req_id;
  assign req_if_a.req_rw    = req_rw;
  assign req_if_a.req_hit   = req_hit;

  assign cnt_down_idle = '{id: 4'd0, rw: 1'b0, valid: 1'b0};

  // Main instance; underflow is provoked on purpose, so its assertion is off.
  axi_llc_miss_counter #(
    .IdWidth (4), .IdxWidth (3), .CntWidth (4), .EnAssert (1'b0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req        (req_if.slave),
    .cnt_down_i (cnt_down),
    .empty_o    (empty),
    .err_o      (err)
  );

  // Aliasing instance: two index bits, never decremented.
  axi_llc_miss_counter #(
    .IdWidth (4), .IdxWidth (2), .CntWidth (4), .EnAssert (1'b1)
  ) dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .req        (req_if_a.slave),
    .cnt_down_i (cnt_down_idle),
    .empty_o    (empty_a),
    .err_o      (err_a)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [3:0] id, input bit rw, input bit hit);
    req_valid = v;
    req_id    = id;
    req_rw    = rw;
    req_hit   = hit;
  endtask

  task automatic set_dn(input bit v, input logic [3:0] id, input bit rw);
    cnt_down = '{id: id, rw: rw, valid: v};
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b0, 4'd0, 1'b0, 1'b1);
    set_dn(1'b0, 4'd0, 1'b0);
    tick();
    tick();
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Hit on an idle index takes the bypass.
    set_req(1'b1, 4'd3, 1'b0, 1'b1);
    #1;
    check_eq("hit_idle_route", 32'(req_if.route_miss), 32'd0);
    check_eq("hit_idle_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    set_req(1'b0, 4'd0, 1'b0, 1'b1);
    check_eq("hit_idle_cnt", 32'(dut.cnt[3]), 32'd0);
    check_eq("hit_idle_empty", 32'(empty), 32'd1);

    // Miss on {rd,3}, then a hit on {rd,3} must follow it.
    set_req(1'b1, 4'd3, 1'b0, 1'b0);
    #1;
    check_eq("miss3_route", 32'(req_if.route_miss), 32'd1);
    check_eq("miss3_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    check_eq("miss3_cnt", 32'(dut.cnt[3]), 32'd1);
    check_eq("miss3_empty", 32'(empty), 32'd0);
    set_req(1'b1, 4'd3, 1'b0, 1'b1);
    #1;
    check_eq("hit3_after_miss_route", 32'(req_if.route_miss), 32'd1);
    tick();
    check_eq("hit3_after_miss_cnt", 32'(dut.cnt[3]), 32'd2);
    // Write direction has its own counter.
    set_req(1'b1, 4'd3, 1'b1, 1'b1);
    #1;
    check_eq("hit3_wr_route", 32'(req_if.route_miss), 32'd0);
    tick();
    set_req(1'b0, 4'd0, 1'b0, 1'b1);
    check_eq("hit3_wr_cnt", 32'(dut.cnt[11]), 32'd0);

    // Drain {rd,3}.
    set_dn(1'b1, 4'd3, 1'b0);
    tick();
    tick();
    set_dn(1'b0, 4'd0, 1'b0);
    check_eq("drain3_cnt", 32'(dut.cnt[3]), 32'd0);
    tick();
    check_eq("drain3_empty", 32'(empty), 32'd1);

    // Fill {wr,5} to 15, a 16th miss stalls until a same-index decrement.
    set_req(1'b1, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      #1;
      check_eq($sformatf("fill_ready_%0d", i), 32'(req_if.req_ready), 32'd1);
      tick();
    end
    check_eq("fill_cnt", 32'(dut.cnt[13]), 32'd15);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("full_stall_%0d", i), 32'(req_if.req_ready), 32'd0);
      check_eq($sformatf("full_route_%0d", i), 32'(req_if.route_miss), 32'd1);
      tick();
      check_eq($sformatf("full_hold_cnt_%0d", i), 32'(dut.cnt[13]), 32'd15);
    end
    set_dn(1'b1, 4'd5, 1'b1);
    #1;
    check_eq("full_release_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    set_req(1'b0, 4'd0, 1'b0, 1'b1);
    check_eq("full_release_cnt", 32'(dut.cnt[13]), 32'd15);
    for (int i = 0; i < 14; i++) tick();
    check_eq("drain5_cnt_1", 32'(dut.cnt[13]), 32'd1);
    check_eq("drain5_empty_0", 32'(empty), 32'd0);
    tick();
    set_dn(1'b0, 4'd0, 1'b0);
    check_eq("drain5_cnt_0", 32'(dut.cnt[13]), 32'd0);
    check_eq("drain5_empty_1", 32'(empty), 32'd1);

    // Hit coinciding with the last decrement on its index takes the bypass.
    set_req(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    check_eq("byp_pre_cnt", 32'(dut.cnt[2]), 32'd1);
    set_req(1'b1, 4'd2, 1'b0, 1'b1);
    set_dn(1'b1, 4'd2, 1'b0);
    #1;
    check_eq("byp_route", 32'(req_if.route_miss), 32'd0);
    check_eq("byp_ready", 32'(req_if.req_ready), 32'd1);
    check_eq("byp_empty_before", 32'(empty), 32'd0);
    tick();
    set_req(1'b0, 4'd0, 1'b0, 1'b1);
    set_dn(1'b0, 4'd0, 1'b0);
    check_eq("byp_cnt", 32'(dut.cnt[2]), 32'd0);
    check_eq("byp_empty_after", 32'(empty), 32'd1);

    // Decrement at zero: counter holds, error is sticky until reset.
    check_eq("uf_err_before", 32'(err), 32'd0);
    set_dn(1'b1, 4'd7, 1'b0);
    tick();
    set_dn(1'b0, 4'd0, 1'b0);
    check_eq("uf_cnt", 32'(dut.cnt[7]), 32'd0);
    check_eq("uf_err", 32'(err), 32'd1);
    tick();
    tick();
    check_eq("uf_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("uf_err_reset", 32'(err), 32'd0);
    check_eq("reset_cnt13", 32'(dut.cnt[13]), 32'd0);
    check_eq("reset_empty_a", 32'(empty_a), 32'd1);

    // Aliasing: with two index bits ID 1 and ID 5 share a counter.
    set_req(1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    set_req(1'b1, 4'd5, 1'b0, 1'b1);
    #1;
    check_eq("alias_route_a", 32'(req_if_a.route_miss), 32'd1);
    check_eq("alias_route_wide", 32'(req_if.route_miss), 32'd0);
    tick();
    set_req(1'b0, 4'd0, 1'b0, 1'b1);
    check_eq("alias_cnt_a", 32'(dut_a.cnt[1]), 32'd2);
    check_eq("alias_err_a", 32'(err_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
